// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-requester round-robin bus arbiter with registered 2:1 data mux.
// Define ARB_TIMEOUT_EN to force rotation after HOLD_MAX owned cycles while the other side waits.
module bus_arbiter2 #(
  parameter int DATA_W = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid
);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  state_t state, next;
  logic last_owner, rot0, rot1;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;
  assign rot0 = (hold_cnt == HOLD_LAST) && req1;
  assign rot1 = (hold_cnt == HOLD_LAST) && req0;
  always_ff @(posedge clock or posedge reset)
    if (reset) hold_cnt <= '0;
    else if (next != state || next == IDLE) hold_cnt <= '0;
    else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
`else
  logic unused_hold;
  assign unused_hold = HOLD_MAX > 0;
  assign rot0 = 1'b0;
  assign rot1 = 1'b0;
`endif
  assign gnt0 = state == OWN0;
  assign gnt1 = state == OWN1;
  always_comb begin
    next = IDLE;
    if (state == IDLE) next = (req0 && req1) ? (last_owner ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (state == OWN0) next = (req0 && !rot0) ? OWN0 : req1 ? OWN1 : IDLE;
    else if (state == OWN1) next = (req1 && !rot1) ? OWN1 : req0 ? OWN0 : IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_owner <= 1'b1;
      bus_data   <= '0;
      bus_valid  <= 1'b0;
    end else begin
      state <= next;
      if (next != IDLE) begin
        sel        <= next == OWN1;
        last_owner <= next == OWN1;
      end
      if (state != IDLE) bus_data <= sel ? data1 : data0;
      bus_valid <= (gnt0 && req0) || (gnt1 && req1);
    end
endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2: table-driven check of bus_arbiter2 plus hold, glitch and async-reset sequences.
module tb_bus_arbiter2;
  logic clock = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0, bus_data;
  logic gnt0, gnt1, sel, bus_valid;
  int total = 0, bad = 0;
  typedef struct {
    logic r0, r1;
    logic [7:0] d0, d1;
    logic [11:0] exp;
  } vec_t;
  vec_t tv[$];
  bus_arbiter2 #(.DATA_W(8), .HOLD_MAX(4)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .sel(sel), .bus_data(bus_data), .bus_valid(bus_valid)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {g0,g1,sel,bv}=%b data=%h, want {g0,g1,sel,bv}=%b data=%h", name, act[11:8], act[7:0], exp[11:8], exp[7:0]);
    end
  endtask
  function automatic logic [11:0] outs();
    return {gnt0, gnt1, sel, bus_valid, bus_data};
  endfunction
  task automatic add(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] f, input logic [7:0] bd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.exp = {f, bd};
    tv.push_back(v);
  endtask
  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 chk("reset_state", outs(), 12'h000);
    reset = 1'b0;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    add(1, 1, 8'hA5, 8'h3C, 4'b1000, 8'h00);
    add(1, 1, 8'hA5, 8'h3C, 4'b1001, 8'hA5);
    add(1, 1, 8'hA5, 8'h3C, 4'b1001, 8'hA5);
    add(0, 1, 8'hA5, 8'h3C, 4'b0110, 8'hA5);
    add(0, 1, 8'hA5, 8'h3C, 4'b0111, 8'h3C);
    add(0, 0, 8'hA5, 8'h3C, 4'b0010, 8'h3C);
    add(1, 1, 8'h5A, 8'hC3, 4'b1000, 8'h3C);
    add(0, 0, 8'h5A, 8'hC3, 4'b0000, 8'h5A);
    add(0, 1, 8'h5A, 8'h77, 4'b0110, 8'h5A);
    add(0, 0, 8'h5A, 8'h77, 4'b0010, 8'h77);
    add(1, 1, 8'h5A, 8'hC3, 4'b1000, 8'h77);
    add(1, 0, 8'h5A, 8'hC3, 4'b1001, 8'h5A);
    add(0, 0, 8'h5A, 8'hC3, 4'b0000, 8'h5A);
    add(1, 1, 8'h5A, 8'hC3, 4'b0110, 8'h5A);
    add(1, 1, 8'h5A, 8'hC3, 4'b0111, 8'hC3);
    add(1, 0, 8'h5A, 8'hC3, 4'b1000, 8'hC3);
    add(1, 0, 8'h5A, 8'hC3, 4'b1001, 8'h5A);
    add(0, 0, 8'h5A, 8'hC3, 4'b0000, 8'h5A);
    do_reset();
    foreach (tv[i]) begin
      req0 = tv[i].r0; req1 = tv[i].r1; data0 = tv[i].d0; data1 = tv[i].d1;
      step();
      chk($sformatf("vec%0d", i), outs(), tv[i].exp);
    end
    // a req1 pulse entirely between edges must not be granted
    #2 req1 = 1'b1;
    #2 req1 = 1'b0;
    step();
    chk("glitch", {gnt0, gnt1, 10'h0}, 12'h000);
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic [1:0] eg;
      step();
`ifdef ARB_TIMEOUT_EN
      eg = (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
`else
      eg = 2'b10;
`endif
      chk($sformatf("hold%0d", k), {gnt0, gnt1, 10'h0}, {eg, 10'h0});
    end
    do_reset();
    data1 = 8'h99;
    req1 = 1'b1;
    step();
    chk("own1_entry", outs(), {4'b0110, 8'h00});
    step();
    chk("own1_valid", outs(), {4'b0111, 8'h99});
    #2 reset = 1'b1;
    #1 chk("async_reset", outs(), 12'h000);
    #3 reset = 1'b0;
    step();
    chk("regrant1", outs(), {4'b0110, 8'h00});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
